// File: rtl/snd_scheduler_if.sv
// Player-side handshake between the sound scheduler and the ROM sample player.
interface snd_scheduler_if #(
  parameter int ADDR_W = 20
);
  logic              play_start;
  logic              play_stop;
  logic [ADDR_W-1:0] play_start_addr;
  logic [ADDR_W-1:0] play_end_addr;
  logic              play_busy;
  logic              play_done;

  modport master (
    output play_start, play_stop, play_start_addr, play_end_addr,
    input  play_busy, play_done
  );

  modport slave (
    input  play_start, play_stop, play_start_addr, play_end_addr,
    output play_busy, play_done
  );
endinterface

// File: rtl/snd_scheduler.sv
// Fixed-priority one-shot sound scheduler: latches request edges, looks up ROM
// bounds and launches one play at a time, with optional preemption and a watchdog.
module snd_scheduler #(
  parameter int NUM_SND = 6,
  parameter int ADDR_W  = 20,
  parameter int PREEMPT = 1,
  parameter int TIMEOUT = 2000000
) (
  input  logic               clk_50,
  input  logic               reset,
  input  logic [NUM_SND-1:0] req,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_idx,
  input  logic [ADDR_W-1:0]  cfg_start,
  input  logic [ADDR_W-1:0]  cfg_end,
  snd_scheduler_if.master    play,
  output logic               active,
  output logic [2:0]         cur_idx,
  output logic [7:0]         drop_count,
  output logic               timeout_err
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_PLAY, S_STOP, S_ABORT} state_e;

  state_e             state_q, state_d;
  logic [NUM_SND-1:0] req_q, pend_q, pend_d, clr, edge_w, vld_q;
  logic [ADDR_W-1:0]  tbl_s [NUM_SND];
  logic [ADDR_W-1:0]  tbl_e [NUM_SND];
  logic [ADDR_W-1:0]  addr_s_q, addr_s_d, addr_e_q, addr_e_d;
  logic [2:0]         cur_q, cur_d, sel;
  logic [7:0]         drop_q, drop_d;
  logic               terr_q, terr_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               any, hi, sel_ok, cfg_hit;

  assign edge_w  = req & ~req_q;
  assign cfg_hit = cfg_we && ({29'd0, cfg_idx} < 32'(NUM_SND));

  // Later (higher) indices overwrite earlier ones, so sel ends on the winner.
  always_comb begin
    sel = '0;
    any = 1'b0;
    hi  = 1'b0;
    for (int i = 0; i < NUM_SND; i++) begin
      if (pend_q[i]) begin
        sel = 3'(i);
        any = 1'b1;
        if (3'(i) > cur_q) hi = 1'b1;
      end
    end
  end

  assign sel_ok = vld_q[sel] && (tbl_s[sel] <= tbl_e[sel]);

  always_comb begin
    state_d  = state_q;
    clr      = '0;
    addr_s_d = addr_s_q;
    addr_e_d = addr_e_q;
    cur_d    = cur_q;
    drop_d   = drop_q;
    terr_d   = terr_q;
    wd_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (any) begin
          clr[sel] = 1'b1;
          if (sel_ok) begin
            addr_s_d = tbl_s[sel];
            addr_e_d = tbl_e[sel];
            cur_d    = sel;
            state_d  = S_START;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      S_START: state_d = S_PLAY;
      S_PLAY: begin
        wd_d = wd_q + 1'b1;
        if (play.play_done) begin
          state_d = S_IDLE;
        end else if ((PREEMPT != 0) && hi) begin
          state_d = S_STOP;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      // play_stop is issued only in S_STOP; S_ABORT just drains the player.
      S_STOP:  state_d = play.play_busy ? S_ABORT : S_IDLE;
      S_ABORT: if (!play.play_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A fresh edge outranks a same-cycle grant clear.
    pend_d = (pend_q & ~clr) | edge_w;
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      pend_q   <= '0;
      vld_q    <= '0;
      addr_s_q <= '0;
      addr_e_q <= '0;
      cur_q    <= '0;
      drop_q   <= '0;
      terr_q   <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req;
      pend_q   <= pend_d;
      addr_s_q <= addr_s_d;
      addr_e_q <= addr_e_d;
      cur_q    <= cur_d;
      drop_q   <= drop_d;
      terr_q   <= terr_d;
      wd_q     <= wd_d;
      if (cfg_hit) vld_q[cfg_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_50) begin
    if (cfg_hit) begin
      tbl_s[cfg_idx] <= cfg_start;
      tbl_e[cfg_idx] <= cfg_end;
    end
  end

  assign play.play_start      = (state_q == S_START);
  assign play.play_stop       = (state_q == S_STOP);
  assign play.play_start_addr = addr_s_q;
  assign play.play_end_addr   = addr_e_q;
  assign active               = (state_q != S_IDLE);
  assign cur_idx              = cur_q;
  assign drop_count           = drop_q;
  assign timeout_err          = terr_q;
endmodule
